scic_io_port: RTL

Memory-mapped I/O responder for the SCIC core's I/O bus. The core is the initiator; this block answers its read and write requests.
- Switch side: synchronizes and debounces the 4 board switches, then flags each debounced change with a sticky status bit and an optional interrupt.
- LED side: holds the LED output register written by the core.

---
 rtl/scic_io_port.sv | 137 +++++++++++++
 1 files changed

// File: rtl/scic_io_port.sv
// SCIC I/O-bus responder: debounced switch inputs with sticky change flag and
// interrupt, plus a core-writable LED register.

module scic_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module scic_io_port #(
  parameter int SW_W            = 4,
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        io_addr,
  input  logic              io_rd,
  input  logic              io_wr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_ready,
  input  logic [SW_W-1:0]   switches,
  output logic [SW_W-1:0]   LEDs,
  output logic              sw_irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, COUNT} db_state_t;

  db_state_t         state;
  logic [SW_W-1:0]   sync, stable, cand;
  logic [CW-1:0]     cnt;
  logic              changed, irq_en, accept, rd_en;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_wdata;

  assign unused_wdata = ^io_wdata;

  for (genvar i = 0; i < SW_W; i++) begin : g_sync
    scic_sync2 u_sync (.clock(clock), .reset(reset), .d(switches[i]), .q(sync[i]));
  end

  // Counter reaching CNT_LAST while still matching completes DEBOUNCE_CYCLES
  // stable cycles counted from the first differing synchronized sample.
  assign accept = (state == COUNT) && (sync == cand) && (cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      stable <= '0;
      cand   <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (sync != stable) begin
          cand  <= sync;
          cnt   <= CW'(1);
          state <= COUNT;
        end
        COUNT: begin
          if (sync == cand) begin
            if (cnt == CNT_LAST) begin
              stable <= cand;
              cnt    <= '0;
              state  <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (sync == stable) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cand <= sync;
            cnt  <= CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A simultaneous write takes the cycle; the read half is dropped.
  assign rd_en = io_rd & ~io_wr;

  always_comb begin
    rd_mux = '0;
    case (io_addr)
      2'd0: rd_mux[SW_W-1:0] = stable;
      2'd1: rd_mux[0]        = changed;
      2'd2: rd_mux[SW_W-1:0] = LEDs;
      2'd3: rd_mux[0]        = irq_en;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_ready <= 1'b0;
      io_rdata <= '0;
      LEDs     <= '0;
      irq_en   <= 1'b0;
      changed  <= 1'b0;
      sw_irq   <= 1'b0;
    end else begin
      io_ready <= io_rd | io_wr;
      io_rdata <= rd_en ? rd_mux : '0;
      if (io_wr) begin
        case (io_addr)
          2'd2:    LEDs   <= io_wdata[SW_W-1:0];
          2'd3:    irq_en <= io_wdata[0];
          default: ;
        endcase
      end
      // Set beats read-to-clear so an acceptance is never lost.
      if (accept)
        changed <= 1'b1;
      else if (rd_en && io_addr == 2'd1)
        changed <= 1'b0;
      sw_irq <= changed & irq_en;
    end
  end
endmodule
